gpio_port: RTL

- Parametrised GPIO peripheral on the CPU peripheral bus.
- Replaces the fixed 8-pin, 2-register GPIO block with:
  - configurable pin count
  - atomic set/clear/toggle writes
  - 2-flop input synchronisation
  - per-pin edge-detect interrupts with write-1-to-clear pending flags
- Sits behind the bus decoder; its irq output feeds the CPU interrupt line.

---
 rtl/gpio_port.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gpio_port.sv
// Parametrised GPIO peripheral: direction/output registers, atomic set/clear/toggle,
// 2-flop input sync and edge interrupts. Define GPIO_DEBOUNCE_EN to add per-pin debounce.
module gpio_port #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       bus_address,
    input  logic [7:0]       bus_data_tx,
    output logic [7:0]       bus_data_rx,
    input  logic             bus_read,
    input  logic             bus_write,
    output logic             bus_wait,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_direction,
    output logic             irq
);

    logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d, irqEn_q, irqEn_d;
    logic [WIDTH-1:0] pend_q, pend_d, riseEn_q, riseEn_d, fallEn_q, fallEn_d;
    logic [WIDTH-1:0] s1_q, s2_q, prev_q, sample;
    logic [WIDTH-1:0] riseEv, fallEv, w1cMask, wrData, rdField;
    logic [8:0]       unusedBits;

    // Reads are side-effect free, so the read strobe carries no information here.
    assign unusedBits = {bus_read, bus_data_tx};
    assign wrData     = bus_data_tx[WIDTH-1:0];
    assign bus_wait   = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           v_q, v_d;

    // The sample only follows s2 once it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        cnt_d = '0;
        v_d   = v_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != v_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    v_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            v_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            v_q   <= v_d;
        end
    end

    assign sample = v_q;
`else
    assign sample = s2_q;
`endif

    assign riseEv = sample & ~prev_q & riseEn_q;
    assign fallEv = ~sample & prev_q & fallEn_q;

    always_comb begin
        dir_d    = dir_q;
        out_d    = out_q;
        irqEn_d  = irqEn_q;
        riseEn_d = riseEn_q;
        fallEn_d = fallEn_q;
        w1cMask  = '0;
        if (bus_write) begin
            case (bus_address)
                4'd0:    dir_d    = wrData;
                4'd1:    out_d    = wrData;
                4'd3:    out_d    = out_q | wrData;
                4'd4:    out_d    = out_q & ~wrData;
                4'd5:    out_d    = out_q ^ wrData;
                4'd6:    irqEn_d  = wrData;
                4'd7:    w1cMask  = wrData;
                4'd8:    riseEn_d = wrData;
                4'd9:    fallEn_d = wrData;
                default: ;
            endcase
        end
        // New events are OR-ed in after the clear so a coincident edge survives the W1C.
        pend_d = (pend_q & ~w1cMask) | riseEv | fallEv;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q    <= '0;
            out_q    <= '0;
            irqEn_q  <= '0;
            pend_q   <= '0;
            riseEn_q <= '0;
            fallEn_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            irqEn_q  <= irqEn_d;
            pend_q   <= pend_d;
            riseEn_q <= riseEn_d;
            fallEn_q <= fallEn_d;
            s1_q     <= gpio_in;
            s2_q     <= s1_q;
            prev_q   <= sample;
        end
    end

    always_comb begin
        rdField = '0;
        case (bus_address)
            4'd0:    rdField = dir_q;
            4'd1:    rdField = out_q;
            4'd2:    rdField = sample;
            4'd6:    rdField = irqEn_q;
            4'd7:    rdField = pend_q;
            4'd8:    rdField = riseEn_q;
            4'd9:    rdField = fallEn_q;
            default: rdField = '0;
        endcase
        bus_data_rx              = 8'h00;
        bus_data_rx[WIDTH-1:0]   = rdField;
    end

    assign gpio_out       = out_q;
    assign gpio_direction = dir_q;
    assign irq            = |(pend_q & irqEn_q);

endmodule
